// File: rtl/autb_csr_bank.sv
// autb_csr_bank: CSR bank sitting between the autb_csr agent driver and the analog DUT model.
// Control words (addresses 0..NUM_WR-1) drive ctrl_out; status words (NUM_WR..NUM_WR+NUM_RO-1)
// are read through a 2-flop synchronizer. Every accepted control write holds its response
// back for SETTLE_CYCLES clocks to model analog settling.
// Optional feature macro: AUTB_CSR_RO_WRITE_ERR_EN -- when defined, writes to readonly
// addresses respond with rsp_err=1; otherwise they are silently dropped with rsp_err=0.
module autb_csr_bank #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned NUM_WR        = 8,
    parameter int unsigned NUM_RO        = 8,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned SETTLE_CYCLES = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [NUM_WR*DATA_W-1:0] ctrl_out,
    input  logic [NUM_RO*DATA_W-1:0] status_in,
    output logic                     settling
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

`ifdef AUTB_CSR_RO_WRITE_ERR_EN
    localparam logic RoWriteErr = 1'b1;
`else
    localparam logic RoWriteErr = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [NUM_WR*DATA_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic [NUM_RO*DATA_W-1:0] sync1_q, sync1_d;
    logic [NUM_RO*DATA_W-1:0] sync2_q, sync2_d;

    logic [31:0]       addr_ext;
    logic              in_wr;
    logic              in_ro;
    logic              accept;
    logic [DATA_W-1:0] rd_ctrl;
    logic [DATA_W-1:0] rd_stat;

    assign addr_ext = 32'(req_addr);
    assign in_wr    = addr_ext < NUM_WR;
    assign in_ro    = !in_wr && (addr_ext < NUM_WR + NUM_RO);
    assign accept   = req_valid & ready_q;

    // Read mux: control word or synchronized status word selected by the request address.
    always_comb begin
        rd_ctrl = '0;
        rd_stat = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (addr_ext == i) rd_ctrl = ctrl_q[i*DATA_W +: DATA_W];
        end
        for (int unsigned i = 0; i < NUM_RO; i++) begin
            if (addr_ext == NUM_WR + i) rd_stat = sync2_q[i*DATA_W +: DATA_W];
        end
    end

    // Next-state: request decode, settle countdown and response handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        sync1_d = status_in;
        sync2_d = sync1_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StResp;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (in_wr) begin
                        if (req_write) begin
                            for (int unsigned i = 0; i < NUM_WR; i++) begin
                                if (addr_ext == i) ctrl_d[i*DATA_W +: DATA_W] = req_wdata;
                            end
                            // Same-value writes settle too; zero settle responds directly.
                            if (SETTLE_CYCLES != 0) begin
                                state_d = StSettle;
                                cnt_d   = CntLoad;
                            end
                        end else begin
                            rdata_d = rd_ctrl;
                        end
                    end else if (in_ro) begin
                        if (req_write) err_d = RoWriteErr;
                        else           rdata_d = rd_stat;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSettle: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
    end

    // State register with synchronous reset; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == StResp);
    assign settling  = (state_q == StSettle);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign ctrl_out  = ctrl_q;

endmodule
